// File: rtl/xcm_clk_rst_seq.sv
// PLL reset/lock sequencer: pulses the PLL reset, qualifies the synchronised lock
// flag and releases the system reset only after a stable-lock window.
module xcm_clk_rst_seq #(
  parameter int PLL_RST_CYCLES = 16,
  parameter int LOCK_TIMEOUT   = 50000,
  parameter int STABLE_CYCLES  = 1024,
  parameter int CNT_W          = 8
) (
  input  logic             refclk,
  input  logic             rst,
  input  logic             locked,
  input  logic             soft_rst,
  output logic             pll_rst,
  output logic             sys_rst,
  output logic             ready,
  output logic [1:0]       state,
  output logic [CNT_W-1:0] timeout_cnt,
  output logic [CNT_W-1:0] lock_loss_cnt
);

  localparam int MAX_A   = (PLL_RST_CYCLES > LOCK_TIMEOUT) ? PLL_RST_CYCLES : LOCK_TIMEOUT;
  localparam int MAX_CYC = (MAX_A > STABLE_CYCLES) ? MAX_A : STABLE_CYCLES;
  localparam int TMR_W   = ($clog2(MAX_CYC) < 1) ? 1 : $clog2(MAX_CYC);

  localparam logic [TMR_W-1:0] PLL_LAST = TMR_W'(PLL_RST_CYCLES - 1);
  localparam logic [TMR_W-1:0] TO_LAST  = TMR_W'(LOCK_TIMEOUT - 1);
  localparam logic [TMR_W-1:0] ST_LAST  = TMR_W'(STABLE_CYCLES - 1);

  typedef enum logic [1:0] {
    S_PLL_RST   = 2'd0,
    S_WAIT_LOCK = 2'd1,
    S_STABLE    = 2'd2,
    S_RUN       = 2'd3
  } state_t;

  state_t             state_q, state_d;
  logic [TMR_W-1:0]   tmr_q, tmr_d;
  logic [CNT_W-1:0]   timeout_cnt_q, timeout_cnt_d;
  logic [CNT_W-1:0]   lock_loss_cnt_q, lock_loss_cnt_d;
  logic               locked_m_q, locked_s_q;
  logic               pll_rst_q, pll_rst_d;
  logic               sys_rst_q, sys_rst_d;
  logic               ready_q, ready_d;

  always_comb begin
    state_d         = state_q;
    tmr_d           = tmr_q + TMR_W'(1);
    timeout_cnt_d   = timeout_cnt_q;
    lock_loss_cnt_d = lock_loss_cnt_q;

    case (state_q)
      S_PLL_RST: begin
        if (tmr_q == PLL_LAST) state_d = S_WAIT_LOCK;
      end
      S_WAIT_LOCK: begin
        if (locked_s_q) begin
          state_d = S_STABLE;
        end else if (tmr_q == TO_LAST) begin
          state_d = S_PLL_RST;
          if (timeout_cnt_q != '1) timeout_cnt_d = timeout_cnt_q + CNT_W'(1);
        end
      end
      S_STABLE: begin
        if (!locked_s_q) state_d = S_WAIT_LOCK;
        else if (tmr_q == ST_LAST) state_d = S_RUN;
      end
      default: begin
        // Timer is idle in RUN; lock loss outranks a soft reset request.
        tmr_d = '0;
        if (!locked_s_q) begin
          state_d = S_PLL_RST;
          if (lock_loss_cnt_q != '1) lock_loss_cnt_d = lock_loss_cnt_q + CNT_W'(1);
        end else if (soft_rst) begin
          state_d = S_STABLE;
        end
      end
    endcase

    if (state_d != state_q) tmr_d = '0;

    pll_rst_d = (state_d == S_PLL_RST);
    sys_rst_d = (state_d != S_RUN);
    ready_d   = (state_d == S_RUN);
  end

  always_ff @(posedge refclk or posedge rst) begin
    if (rst) begin
      state_q         <= S_PLL_RST;
      tmr_q           <= '0;
      timeout_cnt_q   <= '0;
      lock_loss_cnt_q <= '0;
      locked_m_q      <= 1'b0;
      locked_s_q      <= 1'b0;
      pll_rst_q       <= 1'b1;
      sys_rst_q       <= 1'b1;
      ready_q         <= 1'b0;
    end else begin
      state_q         <= state_d;
      tmr_q           <= tmr_d;
      timeout_cnt_q   <= timeout_cnt_d;
      lock_loss_cnt_q <= lock_loss_cnt_d;
      locked_m_q      <= locked;
      locked_s_q      <= locked_m_q;
      pll_rst_q       <= pll_rst_d;
      sys_rst_q       <= sys_rst_d;
      ready_q         <= ready_d;
    end
  end

  assign pll_rst       = pll_rst_q;
  assign sys_rst       = sys_rst_q;
  assign ready         = ready_q;
  assign state         = state_q;
  assign timeout_cnt   = timeout_cnt_q;
  assign lock_loss_cnt = lock_loss_cnt_q;

endmodule

// File: tb/tb_xcm_clk_rst_seq.sv
// Directed bench for xcm_clk_rst_seq with small parameters; edge numbers in the
// comments count rising edges after rst is released.
module tb_xcm_clk_rst_seq;

  logic       refclk = 1'b0;
  logic       rst = 1'b0;
  logic       locked = 1'b1;
  logic       soft_rst = 1'b0;
  logic       pll_rst, sys_rst, ready;
  logic [1:0] state;
  logic [1:0] timeout_cnt, lock_loss_cnt;

  int n_assert = 0;
  int n_fail   = 0;

  xcm_clk_rst_seq #(
    .PLL_RST_CYCLES(4),
    .LOCK_TIMEOUT  (20),
    .STABLE_CYCLES (8),
    .CNT_W         (2)
  ) dut (
    .refclk        (refclk),
    .rst           (rst),
    .locked        (locked),
    .soft_rst      (soft_rst),
    .pll_rst       (pll_rst),
    .sys_rst       (sys_rst),
    .ready         (ready),
    .state         (state),
    .timeout_cnt   (timeout_cnt),
    .lock_loss_cnt (lock_loss_cnt)
  );

  always #5 refclk = ~refclk;

  task automatic tick();
    @(posedge refclk);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic chk_out(input string tag, input logic [1:0] st, input logic pr, input logic sr);
    $display("%s: state=%0d pll_rst=%0b sys_rst=%0b ready=%0b tmo=%0d loss=%0d",
             tag, state, pll_rst, sys_rst, ready, timeout_cnt, lock_loss_cnt);
    chk({tag, "/state"},   32'(state),   32'(st));
    chk({tag, "/pll_rst"}, 32'(pll_rst), 32'(pr));
    chk({tag, "/sys_rst"}, 32'(sys_rst), 32'(sr));
    chk({tag, "/ready"},   32'(ready),   32'(!sr));
  endtask

  task automatic chk_cnts(input string tag, input logic [1:0] tmo, input logic [1:0] loss);
    chk({tag, "/timeout_cnt"},   32'(timeout_cnt),   32'(tmo));
    chk({tag, "/lock_loss_cnt"}, 32'(lock_loss_cnt), 32'(loss));
  endtask

  task automatic do_reset();
    rst = 1'b1;
    ticks(2);
    rst = 1'b0;
  endtask

  initial begin
    // Reset values before any clock edge
    #1 rst = 1'b1;
    #2;
    chk_out("reset", 2'd0, 1'b1, 1'b1);
    chk_cnts("reset", 2'd0, 2'd0);
    ticks(2);
    rst = 1'b0;

    // Scenario 1: locked high throughout
    ticks(3);                                  // edge 3
    chk_out("s1_e3", 2'd0, 1'b1, 1'b1);
    tick();                                    // edge 4
    chk_out("s1_e4", 2'd1, 1'b0, 1'b1);
    tick();                                    // edge 5
    chk_out("s1_e5", 2'd2, 1'b0, 1'b1);
    ticks(7);                                  // edge 12
    chk_out("s1_e12", 2'd2, 1'b0, 1'b1);
    tick();                                    // edge 13
    chk_out("s1_e13", 2'd3, 1'b0, 1'b0);
    chk_cnts("s1_e13", 2'd0, 2'd0);

    // Scenario 4: locked_s low while STABLE counter is 5
    do_reset();
    ticks(5);                                  // edge 5: STABLE
    chk_out("s4_e5", 2'd2, 1'b0, 1'b1);
    ticks(3);                                  // edge 8
    locked = 1'b0;
    tick();                                    // edge 9
    locked = 1'b1;
    tick();                                    // edge 10
    chk_out("s4_e10", 2'd2, 1'b0, 1'b1);
    tick();                                    // edge 11
    chk_out("s4_e11", 2'd1, 1'b0, 1'b1);
    chk_cnts("s4_e11", 2'd0, 2'd0);
    tick();                                    // edge 12
    chk_out("s4_e12", 2'd2, 1'b0, 1'b1);
    ticks(7);                                  // edge 19
    chk_out("s4_e19", 2'd2, 1'b0, 1'b1);
    tick();                                    // edge 20
    chk_out("s4_e20", 2'd3, 1'b0, 1'b0);

    // Scenario 3: one-cycle lock glitch in RUN
    locked = 1'b0;
    tick();                                    // edge 21
    locked = 1'b1;
    tick();                                    // edge 22
    chk_out("s3_e22", 2'd3, 1'b0, 1'b0);
    tick();                                    // edge 23
    chk_out("s3_e23", 2'd0, 1'b1, 1'b1);
    chk_cnts("s3_e23", 2'd0, 2'd1);
    ticks(3);                                  // edge 26
    chk_out("s3_e26", 2'd0, 1'b1, 1'b1);
    tick();                                    // edge 27
    chk_out("s3_e27", 2'd1, 1'b0, 1'b1);
    tick();                                    // edge 28
    chk_out("s3_e28", 2'd2, 1'b0, 1'b1);
    ticks(7);                                  // edge 35
    chk_out("s3_e35", 2'd2, 1'b0, 1'b1);
    tick();                                    // edge 36
    chk_out("s3_e36", 2'd3, 1'b0, 1'b0);

    // Scenario 5a: soft reset sampled at edge 37
    soft_rst = 1'b1;
    tick();                                    // edge 37
    soft_rst = 1'b0;
    chk_out("s5_e37", 2'd2, 1'b0, 1'b1);
    ticks(7);                                  // edge 44
    chk_out("s5_e44", 2'd2, 1'b0, 1'b1);
    tick();                                    // edge 45
    chk_out("s5_e45", 2'd3, 1'b0, 1'b0);
    chk_cnts("s5_e45", 2'd0, 2'd1);

    // Scenario 5b: soft_rst on the edge where locked_s is low
    locked = 1'b0;
    tick();                                    // edge 46
    tick();                                    // edge 47
    chk_out("s5_e47", 2'd3, 1'b0, 1'b0);
    soft_rst = 1'b1;
    tick();                                    // edge 48
    soft_rst = 1'b0;
    locked = 1'b1;
    chk_out("s5_e48", 2'd0, 1'b1, 1'b1);
    chk_cnts("s5_e48", 2'd0, 2'd2);

    // Scenario 6: asynchronous reset mid-STABLE
    ticks(7);                                  // edge 55: STABLE since edge 53
    chk_out("s6_pre", 2'd2, 1'b0, 1'b1);
    chk_cnts("s6_pre", 2'd0, 2'd2);
    #3 rst = 1'b1;
    #1;
    chk_out("s6_async", 2'd0, 1'b1, 1'b1);
    chk_cnts("s6_async", 2'd0, 2'd0);

    // Scenario 2: never locked, periodic timeouts and saturation
    locked = 1'b0;
    ticks(3);
    rst = 1'b0;
    for (int e = 1; e <= 100; e++) begin
      logic       in_pll;
      logic [1:0] exp_tmo;
      tick();
      in_pll  = (e < 4) || (e >= 24 && (e % 24) < 4);
      exp_tmo = (e / 24 >= 3) ? 2'd3 : 2'(e / 24);
      if (e % 24 == 0 || e % 24 == 4 || e == 1)
        chk_out($sformatf("s2_e%0d", e), in_pll ? 2'd0 : 2'd1, in_pll, 1'b1);
      chk($sformatf("s2_e%0d/pll_rst", e), 32'(pll_rst), 32'(in_pll));
      chk($sformatf("s2_e%0d/sys_rst", e), 32'(sys_rst), 32'd1);
      chk($sformatf("s2_e%0d/timeout_cnt", e), 32'(timeout_cnt), 32'(exp_tmo));
    end
    chk_cnts("s2_end", 2'd3, 2'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
